// File: rtl/sm83_pkg.sv
// SM83 instruction-assembly types and opcode decode helpers.
// Provides the assembler FSM state, the assembled-packet struct and
// immediate-length / unused-opcode lookups shared by the fetch path.
package sm83_pkg;

  localparam logic [7:0] CB_PREFIX = 8'hCB;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CB     = 3'd1,
    IMM_LO = 3'd2,
    IMM_HI = 3'd3,
    OUT    = 3'd4
  } asm_state_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic        is_cb;
    logic [15:0] imm;
    logic [1:0]  len;
    logic        illegal;
  } instr_pkt_t;

  // Number of immediate bytes that follow an unprefixed opcode.
  function automatic logic [1:0] imm_count(input logic [7:0] op);
    logic [1:0] n;
    n = 2'd0;
    case (op)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hF0, 8'hE8, 8'hF8:
        n = 2'd1;
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
      8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
      8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:
        n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // The eleven opcodes the SM83 leaves unassigned.
  function automatic logic is_illegal(input logic [7:0] op);
    logic r;
    r = 1'b0;
    case (op)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD:
        r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Purpose: circular byte queue feeding the instruction assembler.
// Latency: a pushed byte is visible at pop_data one edge after the push.
// Backpressure: caller must not push when full nor pop when empty.
// Ports: clk/rst (sync, active-high); push/push_data write; pop advances
//        the head; clear empties the queue but keeps a same-edge push as
//        the sole entry; full/empty/count report fill level.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  input  logic                       clear,
  output logic [7:0]                 pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      // A byte arriving on the clear edge becomes the new head at slot 0.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (push) begin
        mem_d[0] = push_data;
        wr_ptr_d = PTR_ONE;
        count_d  = CNT_ONE;
      end
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (count_q == CNT_MAX);
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/instr_assembler.sv
// Purpose: assembles SM83 instructions (opcode, CB prefix, immediates)
//          from a fetched byte stream into one packet per instruction.
// Latency: 1-byte opcode pushed into an empty queue at edge N is valid
//          after edge N+1; back-to-back 1-byte packets issue every cycle.
// Backpressure: byte_ready = !full; packet held stable while !pkt_ready.
// Ports: clk, rst (sync active-high), byte_valid/byte_data/byte_ready in,
//        flush, pkt_valid/pkt_ready and pkt_* fields out, occupancy.
// Option: define INSTR_ASM_ILLEGAL_EN to flag unused opcodes on pkt_illegal.
module instr_assembler
  import sm83_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  output logic                       byte_ready,
  input  logic                       flush,
  output logic                       pkt_valid,
  input  logic                       pkt_ready,
  output logic [7:0]                 pkt_opcode,
  output logic                       pkt_is_cb,
  output logic [15:0]                pkt_imm,
  output logic [1:0]                 pkt_len,
  output logic                       pkt_illegal,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  asm_state_t state_q, state_d;
  instr_pkt_t pkt_q, pkt_d;

  logic       fifo_full, fifo_empty;
  logic [7:0] head;
  logic       push, pop;

  // Decode of the queue head as the first byte of a new instruction.
  instr_pkt_t first_pkt;
  asm_state_t first_state;
  logic [1:0] first_n;

  assign byte_ready = !fifo_full;
  assign push       = byte_valid && !fifo_full;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (byte_data),
    .pop       (pop),
    .clear     (flush),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

  always_comb begin
    first_pkt        = '0;
    first_pkt.opcode = head;
    first_n          = imm_count(head);
    first_state      = OUT;
    if (head == CB_PREFIX) begin
      first_pkt.is_cb = 1'b1;
      first_pkt.len   = 2'd2;
      first_state     = CB;
    end else begin
      first_pkt.len = 2'd1 + first_n;
      first_state   = (first_n == 2'd0) ? OUT : IMM_LO;
`ifdef INSTR_ASM_ILLEGAL_EN
      first_pkt.illegal = is_illegal(head);
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          pkt_d   = first_pkt;
          state_d = first_state;
        end
      end
      CB: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          pkt_d.opcode = head;
          state_d      = OUT;
        end
      end
      IMM_LO: begin
        if (!fifo_empty) begin
          pop            = 1'b1;
          pkt_d.imm[7:0] = head;
          // len==3 is the only case with a second immediate byte.
          state_d        = (pkt_q.len == 2'd3) ? IMM_HI : OUT;
        end
      end
      IMM_HI: begin
        if (!fifo_empty) begin
          pop             = 1'b1;
          pkt_d.imm[15:8] = head;
          state_d         = OUT;
        end
      end
      OUT: begin
        if (pkt_ready) begin
          if (!fifo_empty) begin
            // Chain straight into the next instruction for full throughput.
            pop     = 1'b1;
            pkt_d   = first_pkt;
            state_d = first_state;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      pop     = 1'b0;
      pkt_d   = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
    end
  end

  assign pkt_valid  = (state_q == OUT);
  assign pkt_opcode = pkt_q.opcode;
  assign pkt_is_cb  = pkt_q.is_cb;
  assign pkt_imm    = pkt_q.imm;
  assign pkt_len    = pkt_q.len;
`ifdef INSTR_ASM_ILLEGAL_EN
  assign pkt_illegal = pkt_q.illegal;
`else
  assign pkt_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_assembler.sv
// Directed testbench for instr_assembler (DEPTH = 4).
module tb_instr_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        flush;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [7:0]  pkt_opcode;
  logic        pkt_is_cb;
  logic [15:0] pkt_imm;
  logic [1:0]  pkt_len;
  logic        pkt_illegal;
  logic [2:0]  occupancy;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_assembler #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .flush       (flush),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_opcode  (pkt_opcode),
    .pkt_is_cb   (pkt_is_cb),
    .pkt_imm     (pkt_imm),
    .pkt_len     (pkt_len),
    .pkt_illegal (pkt_illegal),
    .occupancy   (occupancy)
  );

  task automatic apply_reset();
    rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; flush = 1'b0; pkt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic wait_pkt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (pkt_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; byte_valid = 1'b1; byte_data = 8'h3E; flush = 1'b1; pkt_ready = 1'b0;
    @(posedge clk);
    #1;
    tests_run++; if (byte_ready !== 1'b1) begin fails++; $display("FAIL reset_byte_ready: got %b expected 1", byte_ready); end
    tests_run++; if (pkt_valid !== 1'b0) begin fails++; $display("FAIL reset_pkt_valid: got %b expected 0", pkt_valid); end
    tests_run++; if (occupancy !== 3'd0) begin fails++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    tests_run++; if ({pkt_opcode, pkt_is_cb, pkt_imm, pkt_len, pkt_illegal} !== 28'h0)
      begin fails++; $display("FAIL reset_pkt_fields: got %h expected 0", {pkt_opcode, pkt_is_cb, pkt_imm, pkt_len, pkt_illegal}); end
    rst = 1'b0; byte_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    push_byte(8'h00);
    tests_run++; if (pkt_valid !== 1'b0) begin fails++; $display("FAIL single_not_early: got %b expected 0", pkt_valid); end
    @(posedge clk);
    #1;
    tests_run++; if (pkt_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", pkt_valid); end
    tests_run++; if (pkt_opcode !== 8'h00) begin fails++; $display("FAIL single_opcode: got %h expected 00", pkt_opcode); end
    tests_run++; if (pkt_len !== 2'd1) begin fails++; $display("FAIL single_len: got %0d expected 1", pkt_len); end
    tests_run++; if (pkt_imm !== 16'h0000) begin fails++; $display("FAIL single_imm: got %h expected 0000", pkt_imm); end
    tests_run++; if (pkt_is_cb !== 1'b0) begin fails++; $display("FAIL single_is_cb: got %b expected 0", pkt_is_cb); end
  endtask

  task automatic test_imm16();
    bit ok;
    apply_reset();
    push_byte(8'hC3); push_byte(8'h50); push_byte(8'h01);
    wait_pkt(ok);
    tests_run++; if (ok !== 1'b1) begin fails++; $display("FAIL imm16_timeout: got no packet expected one"); end
    tests_run++; if (pkt_opcode !== 8'hC3) begin fails++; $display("FAIL imm16_opcode: got %h expected C3", pkt_opcode); end
    tests_run++; if (pkt_imm !== 16'h0150) begin fails++; $display("FAIL imm16_imm: got %h expected 0150", pkt_imm); end
    tests_run++; if (pkt_len !== 2'd3) begin fails++; $display("FAIL imm16_len: got %0d expected 3", pkt_len); end
  endtask

  task automatic test_imm8();
    bit ok;
    apply_reset();
    push_byte(8'h3E); push_byte(8'h7F);
    wait_pkt(ok);
    tests_run++; if (ok !== 1'b1) begin fails++; $display("FAIL imm8_timeout: got no packet expected one"); end
    tests_run++; if (pkt_opcode !== 8'h3E) begin fails++; $display("FAIL imm8_opcode: got %h expected 3E", pkt_opcode); end
    tests_run++; if (pkt_imm !== 16'h007F) begin fails++; $display("FAIL imm8_imm: got %h expected 007F", pkt_imm); end
    tests_run++; if (pkt_len !== 2'd2) begin fails++; $display("FAIL imm8_len: got %0d expected 2", pkt_len); end
  endtask

  task automatic test_cb();
    bit ok;
    apply_reset();
    push_byte(8'hCB); push_byte(8'h37);
    wait_pkt(ok);
    tests_run++; if (ok !== 1'b1) begin fails++; $display("FAIL cb_timeout: got no packet expected one"); end
    tests_run++; if (pkt_opcode !== 8'h37) begin fails++; $display("FAIL cb_opcode: got %h expected 37", pkt_opcode); end
    tests_run++; if (pkt_is_cb !== 1'b1) begin fails++; $display("FAIL cb_is_cb: got %b expected 1", pkt_is_cb); end
    tests_run++; if (pkt_len !== 2'd2) begin fails++; $display("FAIL cb_len: got %0d expected 2", pkt_len); end
    tests_run++; if (pkt_imm !== 16'h0000) begin fails++; $display("FAIL cb_imm: got %h expected 0000", pkt_imm); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_ops [4];
    exp_ops = '{8'h04, 8'h05, 8'h0C, 8'h14};
    apply_reset();
    push_byte(8'h00); push_byte(8'h04); push_byte(8'h05); push_byte(8'h0C); push_byte(8'h14);
    tests_run++; if (occupancy !== 3'd4) begin fails++; $display("FAIL bp_occupancy_full: got %0d expected 4", occupancy); end
    tests_run++; if (byte_ready !== 1'b0) begin fails++; $display("FAIL bp_byte_ready: got %b expected 0", byte_ready); end
    // Sixth byte offered for several cycles must be refused.
    byte_valid = 1'b1; byte_data = 8'h1C;
    repeat (3) @(posedge clk);
    #1 byte_valid = 1'b0;
    tests_run++; if (occupancy !== 3'd4) begin fails++; $display("FAIL bp_occupancy_held: got %0d expected 4", occupancy); end
    tests_run++; if (pkt_valid !== 1'b1 || pkt_opcode !== 8'h00 || pkt_len !== 2'd1)
      begin fails++; $display("FAIL bp_pkt_held: got valid=%b op=%h len=%0d expected 1 00 1", pkt_valid, pkt_opcode, pkt_len); end
    pkt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      tests_run++; if (pkt_valid !== 1'b1 || pkt_opcode !== exp_ops[i])
        begin fails++; $display("FAIL bp_drain_%0d: got valid=%b op=%h expected 1 %h", i, pkt_valid, pkt_opcode, exp_ops[i]); end
    end
    @(posedge clk);
    #1;
    tests_run++; if (pkt_valid !== 1'b0) begin fails++; $display("FAIL bp_drained: got %b expected 0", pkt_valid); end
    pkt_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    push_byte(8'h00); push_byte(8'h04); push_byte(8'h05);
    tests_run++; if (pkt_valid !== 1'b1 || pkt_opcode !== 8'h00)
      begin fails++; $display("FAIL b2b_first: got valid=%b op=%h expected 1 00", pkt_valid, pkt_opcode); end
    tests_run++; if (occupancy !== 3'd2) begin fails++; $display("FAIL b2b_occupancy: got %0d expected 2", occupancy); end
    pkt_ready = 1'b1;
    @(posedge clk);
    #1;
    tests_run++; if (pkt_valid !== 1'b1 || pkt_opcode !== 8'h04)
      begin fails++; $display("FAIL b2b_second: got valid=%b op=%h expected 1 04", pkt_valid, pkt_opcode); end
    @(posedge clk);
    #1;
    tests_run++; if (pkt_valid !== 1'b1 || pkt_opcode !== 8'h05)
      begin fails++; $display("FAIL b2b_third: got valid=%b op=%h expected 1 05", pkt_valid, pkt_opcode); end
    @(posedge clk);
    #1;
    tests_run++; if (pkt_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b expected 0", pkt_valid); end
    pkt_ready = 1'b0;
  endtask

  task automatic test_flush();
    apply_reset();
    push_byte(8'hCD); push_byte(8'h34);
    flush = 1'b1; byte_valid = 1'b1; byte_data = 8'h76;
    @(posedge clk);
    #1 flush = 1'b0; byte_valid = 1'b0;
    tests_run++; if (pkt_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b expected 0", pkt_valid); end
    tests_run++; if (occupancy !== 3'd1) begin fails++; $display("FAIL flush_occupancy: got %0d expected 1", occupancy); end
    @(posedge clk);
    #1;
    tests_run++; if (pkt_valid !== 1'b1 || pkt_opcode !== 8'h76 || pkt_len !== 2'd1 || pkt_imm !== 16'h0000)
      begin fails++; $display("FAIL flush_next_pkt: got valid=%b op=%h len=%0d imm=%h expected 1 76 1 0000", pkt_valid, pkt_opcode, pkt_len, pkt_imm); end
    // Flush beats a same-edge handshake on a held packet.
    push_byte(8'h00);
    pkt_ready = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 pkt_ready = 1'b0; flush = 1'b0;
    tests_run++; if (pkt_valid !== 1'b0 || occupancy !== 3'd0)
      begin fails++; $display("FAIL flush_over_ready: got valid=%b occ=%0d expected 0 0", pkt_valid, occupancy); end
  endtask

  task automatic test_illegal();
    bit ok;
    logic exp_ill;
`ifdef INSTR_ASM_ILLEGAL_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    apply_reset();
    push_byte(8'hD3);
    wait_pkt(ok);
    tests_run++; if (ok !== 1'b1) begin fails++; $display("FAIL illegal_timeout: got no packet expected one"); end
    tests_run++; if (pkt_illegal !== exp_ill) begin fails++; $display("FAIL illegal_flag: got %b expected %b", pkt_illegal, exp_ill); end
    tests_run++; if (pkt_len !== 2'd1) begin fails++; $display("FAIL illegal_len: got %0d expected 1", pkt_len); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    push_byte(8'h3E); push_byte(8'h00); push_byte(8'hC3); push_byte(8'h50);
    rst = 1'b1; flush = 1'b1; byte_valid = 1'b1; byte_data = 8'hAA;
    @(posedge clk);
    #1 rst = 1'b0; flush = 1'b0; byte_valid = 1'b0;
    tests_run++; if (occupancy !== 3'd0) begin fails++; $display("FAIL rstmid_occupancy: got %0d expected 0", occupancy); end
    tests_run++; if (pkt_valid !== 1'b0 || byte_ready !== 1'b1)
      begin fails++; $display("FAIL rstmid_handshake: got valid=%b ready=%b expected 0 1", pkt_valid, byte_ready); end
    tests_run++; if ({pkt_opcode, pkt_is_cb, pkt_imm, pkt_len} !== 27'h0)
      begin fails++; $display("FAIL rstmid_fields: got %h expected 0", {pkt_opcode, pkt_is_cb, pkt_imm, pkt_len}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_imm16();
    test_imm8();
    test_cb();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/instr_assembler.md
INSTR_ASSEMBLER -- requirements
Module: instr_assembler

Interface
- REQ-001: Parameter DEPTH, default 4, byte-queue entries; SHALL be a power of two, at least 2.
- REQ-002: Port clk, input, 1, sole clock; all state SHALL update on its rising edge.
- REQ-003: Port rst, input, 1, reset; SHALL be synchronous and active-high.
- REQ-004: Port byte_valid, input, 1, fetch byte offered.
- REQ-005: Port byte_data, input, 8, fetched instruction-stream byte.
- REQ-006: Port byte_ready, output, 1, queue can accept a byte.
- REQ-007: Port flush, input, 1, discard all buffered bytes and any partial or held packet; used on control-flow change.
- REQ-008: Port pkt_valid, output, 1, assembled instruction available.
- REQ-009: Port pkt_ready, input, 1, consumer accepts the packet.
- REQ-010: Port pkt_opcode, output, 8, opcode; for CB instructions this is the byte after 0xCB.
- REQ-011: Port pkt_is_cb, output, 1, instruction was 0xCB-prefixed.
- REQ-012: Port pkt_imm, output, 16, immediate: {hi,lo} little-endian; for 1-byte immediates {8'h00,lo}; otherwise 0.
- REQ-013: Port pkt_len, output, 2, total instruction bytes, 1 to 3.
- REQ-014: Port pkt_illegal, output, 1, opcode is one of the 11 unused SM83 opcodes.
- REQ-015: Port occupancy, output, $clog2(DEPTH+1), current queue fill level.

Function
- REQ-016: A byte SHALL be accepted on an edge where byte_valid && byte_ready; byte_ready SHALL equal !full, with no full-queue bypass.
- REQ-017: Queue pointers SHALL wrap modulo DEPTH; a push and pop on the same edge SHALL leave occupancy unchanged.
- REQ-018: FSM states SHALL be IDLE, CB, IMM_LO, IMM_HI and OUT.
- REQ-019: FSM SHALL pop at most one byte per edge, and only when the queue is non-empty.
- REQ-020: IDLE, pop: 0xCB goes to CB; an opcode with N immediate bytes goes to IMM_LO (N>0) or OUT (N=0).
- REQ-021: CB, pop: latch opcode, set is_cb, set len=2, go to OUT.
- REQ-022: IMM_LO, pop: latch lo; go to IMM_HI if N=2, else OUT.
- REQ-023: IMM_HI, pop: latch hi, go to OUT.
- REQ-024: Immediate count SHALL be 1 for 06,0E,16,1E,26,2E,36,3E,10,18,20,28,30,38,C6,CE,D6,DE,E6,EE,F6,FE,E0,F0,E8,F8.
- REQ-025: Immediate count SHALL be 2 for 01,11,21,31,08,C2,C3,C4,CA,CC,CD,D2,D4,DA,DC,EA,FA.
- REQ-026: Immediate count SHALL be 0 for all other opcodes.
- REQ-027: pkt_valid SHALL equal (state==OUT); all pkt_* outputs SHALL be held stable while pkt_valid && !pkt_ready.
- REQ-028: OUT with handshake and non-empty queue SHALL pop the next opcode on the same edge and apply the IDLE transition, giving one 1-byte instruction per cycle.
- REQ-029: OUT with handshake and empty queue SHALL go to IDLE.
- REQ-030: Latency: a 1-byte opcode accepted at edge N into an empty queue SHALL produce pkt_valid=1 after edge N+1.
- REQ-031: flush SHALL clear the queue, go to IDLE and deassert pkt_valid at the next edge, taking priority over pkt_ready.
- REQ-032: A byte accepted on a flush edge SHALL be retained as the sole queue entry.

Reset
- REQ-033: Reset SHALL set state=IDLE, both pointers=0, occupancy=0, byte_ready=1, pkt_valid=0, and all pkt_* fields=0.
- REQ-034: Reset asserted mid-instruction or mid-stall SHALL discard everything and take precedence over flush.

Configuration
- REQ-035: With INSTR_ASM_ILLEGAL_EN defined, pkt_illegal SHALL be 1 for D3,DB,DD,E3,E4,EB,EC,ED,F4,FC,FD, each treated as 1 byte.
- REQ-036: Without INSTR_ASM_ILLEGAL_EN, pkt_illegal SHALL be tied 0 and the decode logic for it omitted.

Structure
- REQ-037: sm83_pkg SHALL gain asm_state_t, an instr_pkt_t struct, an imm_count(opcode) function returning 0 to 2, and an is_illegal(opcode) function.
- REQ-038: The queue SHALL be the sub-module byte_fifo, parametrised by DEPTH, exposing push, pop, clear, full, empty and count.

Verification
- REQ-039: Push 0x00 into an empty queue -> one cycle later pkt_valid=1, opcode=00, len=1, imm=0000, is_cb=0.
- REQ-040: Push C3,50,01 -> packet opcode=C3, imm=0150, len=3.
- REQ-041: Push 3E,7F -> packet opcode=3E, imm=007F, len=2.
- REQ-042: Push CB,37 -> packet opcode=37, is_cb=1, len=2.
- REQ-043: DEPTH=4, pkt_ready=0, push 6 single-byte opcodes -> byte_ready=0 at occupancy 4 and packet held stable.
- REQ-044: Raise pkt_ready with queue 00,04,05 -> packets 00, 04, 05 on three consecutive edges.
- REQ-045: Push CD,34 then flush together with byte 76 -> pkt_valid=0, occupancy=1, next packet opcode=76.
- REQ-046: Push D3 with the macro defined -> pkt_illegal=1, len=1.
- REQ-047: Push D3 without the macro -> pkt_illegal=0.
